// File: rtl/arty_pkg.sv
// Shared types and elaboration-time helpers for the RGB LED PWM controller.
package arty_pkg;

  typedef enum logic [1:0] {
    PWM_OFF     = 2'd0,
    PWM_STATIC  = 2'd1,
    PWM_BLINK   = 2'd2,
    PWM_BREATHE = 2'd3
  } pwm_mode_t;

  // Clock cycles per PWM slot; never below one so tiny clock ratios still run.
  function automatic int pwm_prescale(input longint clk_freq,
                                      input longint pwm_freq,
                                      input int     duty_w);
    longint slot_rate;
    longint quot;
    slot_rate = pwm_freq << duty_w;
    quot      = (slot_rate > 0) ? (clk_freq / slot_rate) : 64'sd1;
    return (quot < 1) ? 1 : int'(quot);
  endfunction

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active config, breathe level tracking and the slot compare.
module pwm_channel
  import arty_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  pwm_mode_t         i_mode,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic [DUTY_W-1:0] i_slot_cnt,
  input  logic              i_boundary,
  input  logic              i_blink_phase,
  input  logic              i_breathe_step,
  output logic              o_pwm
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  pwm_mode_t         r_pend_mode;
  pwm_mode_t         r_act_mode;
  logic [DUTY_W-1:0] r_pend_duty;
  logic [DUTY_W-1:0] r_act_duty;
  logic [DUTY_W-1:0] r_level;
  logic              r_dir_down;
  logic              r_pwm;

  logic [DUTY_W:0]   w_level_inc;
  logic [DUTY_W-1:0] w_level_dec;
  logic [DUTY_W-1:0] w_eff;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_level_inc = {1'b0, r_level} + (DUTY_W+1)'(1);
    w_level_dec = r_level - DUTY_W'(1);
    w_eff       = '0;
    unique case (r_act_mode)
      PWM_OFF:     w_eff = '0;
      PWM_STATIC:  w_eff = r_act_duty;
      PWM_BLINK:   w_eff = i_blink_phase ? r_act_duty : '0;
      PWM_BREATHE: w_eff = r_level;
      default:     w_eff = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_mode <= PWM_OFF;
      r_act_mode  <= PWM_OFF;
      r_pend_duty <= '0;
      r_act_duty  <= '0;
      r_level     <= '0;
      r_dir_down  <= 1'b0;
      r_pwm       <= 1'b0;
    end else begin
      if (i_we) begin
        r_pend_mode <= i_mode;
        r_pend_duty <= i_duty;
      end

      // The breathe step uses the config being loaded at this same boundary.
      if (i_boundary) begin
        r_act_mode <= r_pend_mode;
        r_act_duty <= r_pend_duty;
        if (r_pend_mode == PWM_BREATHE) begin
          if (r_act_mode != PWM_BREATHE) begin
            r_level    <= '0;
            r_dir_down <= 1'b0;
          end else if (i_breathe_step) begin
            if (!r_dir_down) begin
              if (w_level_inc >= {1'b0, r_pend_duty}) begin
                r_level    <= r_pend_duty;
                r_dir_down <= 1'b1;
              end else begin
                r_level <= w_level_inc[DUTY_W-1:0];
              end
            end else if ((r_level == '0) || (w_level_dec == '0)) begin
              r_level    <= '0;
              r_dir_down <= 1'b0;
            end else begin
              r_level <= w_level_dec;
            end
          end
        end
      end

      // Full-scale duty is forced high so the last slot does not glitch low.
      r_pwm <= (w_eff == DUTY_MAX) ? 1'b1 : (i_slot_cnt < w_eff);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// N-channel LED PWM controller: shared slot timebase, blink/breathe sequencers,
// and one pwm_channel per output pin.
module rgb_pwm_ctrl
  import arty_pkg::*;
#(
  parameter int CLK_FREQ      = 12000000,
  parameter int PWM_FREQ      = 1000,
  parameter int N_CH          = 6,
  parameter int DUTY_W        = 8,
  parameter int BLINK_PERIODS = 250,
  parameter int BREATHE_DIV   = 4,
  localparam int CH_W         = safe_clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic [N_CH-1:0]   pwm_o,
  output logic              period_start
);

  localparam int PRESCALE  = pwm_prescale(longint'(CLK_FREQ), longint'(PWM_FREQ), DUTY_W);
  localparam int PRESC_W   = safe_clog2(PRESCALE);
  localparam int BLINK_W   = safe_clog2(BLINK_PERIODS);
  localparam int BREATHE_W = safe_clog2(BREATHE_DIV);

  logic [PRESC_W-1:0]   r_presc;
  logic [DUTY_W-1:0]    r_slot_cnt;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_blink_phase;
  logic [BREATHE_W-1:0] r_breathe_cnt;
  logic                 r_period_start;

  logic w_slot_tick;
  logic w_boundary;
  logic w_breathe_step;

  // The boundary is the edge on which slot_cnt wraps to zero.
  assign w_slot_tick    = (r_presc == PRESC_W'(PRESCALE - 1));
  assign w_boundary     = w_slot_tick && (r_slot_cnt == '1);
  assign w_breathe_step = w_boundary && (r_breathe_cnt == BREATHE_W'(BREATHE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc        <= '0;
      r_slot_cnt     <= '0;
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b1;
      r_breathe_cnt  <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_slot_tick ? '0 : r_presc + PRESC_W'(1);
      r_period_start <= w_boundary;
      if (w_slot_tick) begin
        r_slot_cnt <= r_slot_cnt + DUTY_W'(1);
      end
      if (w_boundary) begin
        if (r_blink_cnt == BLINK_W'(BLINK_PERIODS - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
        r_breathe_cnt <= w_breathe_step ? '0 : r_breathe_cnt + BREATHE_W'(1);
      end
    end
  end

  assign period_start = r_period_start;

  // Writes addressed beyond N_CH match no instance and are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic w_we;
    assign w_we = cfg_we && (cfg_ch == CH_W'(g));

    pwm_channel #(
      .DUTY_W (DUTY_W)
    ) u_channel (
      .clk            (clk),
      .rst            (rst),
      .i_we           (w_we),
      .i_mode         (pwm_mode_t'(cfg_mode)),
      .i_duty         (cfg_duty),
      .i_slot_cnt     (r_slot_cnt),
      .i_boundary     (w_boundary),
      .i_blink_phase  (r_blink_phase),
      .i_breathe_step (w_breathe_step),
      .o_pwm          (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: per-period high-cycle counts checked against a scoreboard.
module tb_rgb_pwm_ctrl;

  localparam int N_CH          = 6;
  localparam int DUTY_W        = 8;
  localparam int PERIOD        = 1024;
  localparam int PRESCALE      = 4;
  localparam int BLINK_PERIODS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [DUTY_W-1:0] cfg_duty = '0;
  logic [N_CH-1:0]   pwm_o;
  logic              period_start;

  rgb_pwm_ctrl #(
    .CLK_FREQ      (1024),
    .PWM_FREQ      (1),
    .N_CH          (N_CH),
    .DUTY_W        (DUTY_W),
    .BLINK_PERIODS (BLINK_PERIODS),
    .BREATHE_DIV   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_duty     (cfg_duty),
    .pwm_o        (pwm_o),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    ch;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   hi[N_CH];
  int   bnd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int ch, input int exp);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // High cycles for a duty-128 BLINK channel in the period opened by boundary k.
  function automatic int blink_exp(input int k);
    return (((k / BLINK_PERIODS) % 2) == 0) ? 512 : 0;
  endfunction

  task automatic do_reset(input string tag);
    int   n;
    logic seen_hi;
    @(negedge clk);
    rst    = 1'b1;
    cfg_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check({tag, "_rst_pwm"}, 32'(pwm_o), 0);
      check({tag, "_rst_period_start"}, 32'(period_start), 0);
    end
    rst     = 1'b0;
    n       = 0;
    seen_hi = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (pwm_o !== '0) seen_hi = 1'b1;
    end while (period_start !== 1'b1 && n < 2 * PERIOD);
    check({tag, "_first_period_start"}, n, PERIOD);
    check({tag, "_pwm_off_after_reset"}, 32'(seen_hi), 0);
    bnd = 1;
  endtask

  // Measure one full period from a period_start cycle; optional config write at cycle wr_at.
  task automatic run_period(input int wr_at, input int wr_ch, input int wr_mode, input int wr_duty);
    int   n;
    exp_t e;
    n = 0;
    while (period_start !== 1'b1 && n < PERIOD + 8) begin
      @(negedge clk);
      n++;
    end
    check("period_align", n, 0);
    for (int c = 0; c < N_CH; c++) hi[c] = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == wr_at) begin
        cfg_we   = 1'b1;
        cfg_ch   = 3'(wr_ch);
        cfg_mode = 2'(wr_mode);
        cfg_duty = DUTY_W'(wr_duty);
      end
      @(negedge clk);
      cfg_we = 1'b0;
      for (int c = 0; c < N_CH; c++) hi[c] += (pwm_o[c] === 1'b1) ? 1 : 0;
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, hi[e.ch], e.exp);
    end
    bnd++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int levels[14] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3};
    int wr_at;
    int wr_ch;
    int wr_mode;
    int wr_duty;

    do_reset("init");

    // STATIC on ch0: duty 64, full scale, zero; coincident writes land one period later.
    sb_push("static64_not_yet", 0, 0);
    sb_push("ch1_idle", 1, 0);
    run_period(0, 0, 1, 64);
    sb_push("static64", 0, 64 * PRESCALE);
    run_period(-1, 0, 0, 0);
    sb_push("static255_coincident_old", 0, 64 * PRESCALE);
    run_period(0, 0, 1, 255);
    sb_push("static255_const_high", 0, PERIOD);
    run_period(0, 0, 1, 0);
    sb_push("static0_const_low", 0, 0);
    run_period(500, 0, 1, 128);
    sb_push("static128_after_midwrite", 0, 128 * PRESCALE);
    sb_push("ch2_before_breathe", 2, 0);
    run_period(0, 2, 3, 4);

    // BREATHE ch2 peak 4, while ch3/ch4 join BLINK one period apart; cfg_ch=6 write mid-run.
    for (int j = 0; j < 14; j++) begin
      sb_push("breathe_ch2", 2, levels[j] * PRESCALE);
      sb_push("static_ch0_hold", 0, 128 * PRESCALE);
      sb_push("blink_ch3", 3, (j >= 1) ? blink_exp(bnd) : 0);
      sb_push("blink_ch4", 4, (j >= 2) ? blink_exp(bnd) : 0);
      sb_push("ch1_untouched", 1, 0);
      sb_push("ch5_untouched", 5, 0);
      wr_at = -1; wr_ch = 0; wr_mode = 0; wr_duty = 0;
      if (j == 0) begin wr_at = 0; wr_ch = 3; wr_mode = 2; wr_duty = 128; end
      if (j == 1) begin wr_at = 0; wr_ch = 4; wr_mode = 2; wr_duty = 128; end
      if (j == 7) begin wr_at = 0; wr_ch = 6; wr_mode = 1; wr_duty = 255; end
      run_period(wr_at, wr_ch, wr_mode, wr_duty);
    end

    // Reset mid-breathe: outputs drop at once, all pending/active config back to OFF.
    for (int i = 0; i < 300; i++) @(negedge clk);
    do_reset("mid");
    for (int c = 0; c < N_CH; c++) sb_push("all_off_after_reset", c, 0);
    run_period(-1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
